// File: rtl/shift_chain_ctrl_if.sv
// Word-side handshake bundle for shift_chain_ctrl: load word in, captured word out,
// clear request and busy status.
interface shift_chain_ctrl_if #(
    parameter int DEPTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [DEPTH-1:0] in_data;
    logic             clr_req;
    logic             out_valid;
    logic             out_ready;
    logic [DEPTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, clr_req, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, clr_req, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_chain_ctrl.sv
// Serial loader/unloader for an external DEPTH-bit CE/sync-reset shift chain,
// with a timed synchronous clear of the chain.
//
// state | meaning
// IDLE  | ready for a word or a clear request; chain frozen
// CLEAR | chain held in sync reset for CLR_CYCLES cycles
// SHIFT | new word shifted in MSB first while old contents shift out
// DONE  | captured old contents offered on out_data until taken
module shift_chain_ctrl #(
    parameter int DEPTH      = 5,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    shift_chain_ctrl_if.slave bus,
    output logic              sh_cen,
    output logic              sh_rst,
    output logic              sh_din,
    input  logic              sh_dout
);
    localparam int CW = $clog2(DEPTH);
    localparam int TW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [TW-1:0] CLR_LOAD = TW'(CLR_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [DEPTH-1:0] word_q, word_d;
    logic [DEPTH-1:0] out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        word_d  = word_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    tmr_d   = CLR_LOAD;
                end else if (bus.in_valid) begin
                    state_d = SHIFT;
                    word_d  = bus.in_data;
                    cnt_d   = '0;
                    out_d   = '0;
                end
            end
            CLEAR: begin
                // down-counter: terminal count of zero ends the clear
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SHIFT: begin
                // word register shifts left so its MSB is always the bit to send
                out_d  = {out_q[DEPTH-2:0], sh_dout};
                word_d = {word_q[DEPTH-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            word_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            word_q  <= word_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_q;
    assign sh_cen        = (state_q == CLEAR) || (state_q == SHIFT);
    assign sh_rst        = (state_q == CLEAR);
    assign sh_din        = (state_q == SHIFT) && word_q[DEPTH-1];
endmodule
